// File: rtl/div_clk_monitor.sv
// rtl/div_clk_monitor.sv - period/high-time checker and lock detector for a divided clock
module div_clk_monitor #(
    parameter int DIV      = 3,
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 4,
    parameter int TIMEOUT  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             div_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             period_err,
    output logic             timeout_err,
    output logic [7:0]       err_count
);

    localparam int MW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W-1:0] DIV_C  = CNT_W'(DIV);
    localparam logic [CNT_W-1:0] TO_C   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
    localparam logic [MW-1:0]    LOCK_C = MW'(LOCK_CNT);
    localparam logic [MW-1:0]    LAST_C = MW'(LOCK_CNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             div_q;
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
    logic [MW-1:0]    match_q, match_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             meas_valid_q, meas_valid_d;
    logic             locked_q, locked_d;
    logic             period_err_q, period_err_d;
    logic             timeout_err_q, timeout_err_d;
    logic [7:0]       err_count_q, err_count_d;
    logic             rise;

    // div_in already lives in the clk domain, so a single delay stage is enough
    // to find its rising edge.
    assign rise = div_in & ~div_q;

    // Next-state: enable dominates, then a missing edge, then a measured rise.
    always_comb begin
        state_d       = state_q;
        per_cnt_d     = per_cnt_q;
        hi_cnt_d      = hi_cnt_q;
        match_d       = match_q;
        period_d      = period_q;
        high_d        = high_q;
        meas_valid_d  = 1'b0;
        locked_d      = locked_q;
        period_err_d  = 1'b0;
        timeout_err_d = 1'b0;
        err_count_d   = err_count_q;

        if (!enable) begin
            state_d   = ST_IDLE;
            per_cnt_d = '0;
            hi_cnt_d  = '0;
            match_d   = '0;
            locked_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // The first rise only opens a measurement window.
                    if (rise) begin
                        state_d   = ST_MEASURE;
                        per_cnt_d = ONE_C;
                        hi_cnt_d  = ONE_C;
                    end
                end
                ST_MEASURE, ST_LOCKED: begin
                    if (per_cnt_q == TO_C) begin
                        // Divider stalled: drop back and wait for a fresh edge,
                        // keeping the last good measurement visible.
                        timeout_err_d = 1'b1;
                        locked_d      = 1'b0;
                        match_d       = '0;
                        state_d       = ST_IDLE;
                        per_cnt_d     = '0;
                        hi_cnt_d      = '0;
                    end else if (rise) begin
                        period_d     = per_cnt_q;
                        high_d       = hi_cnt_q;
                        meas_valid_d = 1'b1;
                        per_cnt_d    = ONE_C;
                        hi_cnt_d     = ONE_C;
                        if (per_cnt_q == DIV_C) begin
                            if (state_q == ST_MEASURE) begin
                                if (match_q == LAST_C) begin
                                    match_d  = LOCK_C;
                                    locked_d = 1'b1;
                                    state_d  = ST_LOCKED;
                                end else begin
                                    match_d = match_q + MW'(1);
                                end
                            end
                        end else begin
                            period_err_d = 1'b1;
                            match_d      = '0;
                            locked_d     = 1'b0;
                            state_d      = ST_MEASURE;
                        end
                    end else begin
                        if (per_cnt_q != TO_C) begin
                            per_cnt_d = per_cnt_q + ONE_C;
                        end
                        hi_cnt_d = hi_cnt_q + CNT_W'(div_in);
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    per_cnt_d = '0;
                    hi_cnt_d  = '0;
                    match_d   = '0;
                    locked_d  = 1'b0;
                end
            endcase
        end

        // Error tally sticks at all-ones instead of wrapping.
        if ((period_err_d || timeout_err_d) && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            div_q         <= 1'b0;
            per_cnt_q     <= '0;
            hi_cnt_q      <= '0;
            match_q       <= '0;
            period_q      <= '0;
            high_q        <= '0;
            meas_valid_q  <= 1'b0;
            locked_q      <= 1'b0;
            period_err_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_in;
            per_cnt_q     <= per_cnt_d;
            hi_cnt_q      <= hi_cnt_d;
            match_q       <= match_d;
            period_q      <= period_d;
            high_q        <= high_d;
            meas_valid_q  <= meas_valid_d;
            locked_q      <= locked_d;
            period_err_q  <= period_err_d;
            timeout_err_q <= timeout_err_d;
            err_count_q   <= err_count_d;
        end
    end

    assign period      = period_q;
    assign high_time   = high_q;
    assign meas_valid  = meas_valid_q;
    assign locked      = locked_q;
    assign period_err  = period_err_q;
    assign timeout_err = timeout_err_q;
    assign err_count   = err_count_q;

endmodule
